// File: rtl/lockstep_align.sv
// Pairs core A/B writebacks from per-core FIFOs and releases them together; orphans are forced out after TIMEOUT.
// Outputs are registered: one cycle after both heads exist; stall_*_o is asserted when a FIFO is full, and a write while full is dropped with ovf_o.
module lockstep_align #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  we_a_i,
  input  logic [ADDR_WIDTH-1:0] addr_a_i,
  input  logic [DATA_WIDTH-1:0] data_a_i,
  input  logic                  we_b_i,
  input  logic [ADDR_WIDTH-1:0] addr_b_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  output logic                  stall_a_o,
  output logic                  stall_b_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] addr_a_o,
  output logic [DATA_WIDTH-1:0] data_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] addr_b_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  timeout_o,
  output logic                  ovf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem_a_q [DEPTH];
  logic [EW-1:0] mem_b_q [DEPTH];
  logic [PW-1:0] wr_a_q, wr_a_d, rd_a_q, rd_a_d;
  logic [PW-1:0] wr_b_q, wr_b_d, rd_b_q, rd_b_d;
  logic [CW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [SW-1:0] skew_q, skew_d;

  logic                  we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic                  timeout_q, timeout_d, ovf_q, ovf_d;

  logic          ne_a, ne_b, full_a, full_b, orphan, tmo, pair;
  logic          push_a, push_b, ovf_hit;
  logic [EW-1:0] head_a, head_b;

  assign ne_a    = (cnt_a_q != '0);
  assign ne_b    = (cnt_b_q != '0);
  assign full_a  = (cnt_a_q == CW'(DEPTH));
  assign full_b  = (cnt_b_q == CW'(DEPTH));
  assign orphan  = ne_a ^ ne_b;
  // Only a genuine orphan times out; if the partner landed as the counter saturated, it pairs normally.
  assign tmo     = orphan && (skew_q == SW'(TIMEOUT));
  assign pair    = ne_a && ne_b && !flush_i;
  assign push_a  = we_a_i && !full_a && !flush_i && !tmo;
  assign push_b  = we_b_i && !full_b && !flush_i && !tmo;
  assign ovf_hit = (we_a_i && full_a) || (we_b_i && full_b);
  assign head_a  = mem_a_q[rd_a_q];
  assign head_b  = mem_b_q[rd_b_q];

  always_comb begin
    wr_a_d    = wr_a_q;
    rd_a_d    = rd_a_q;
    cnt_a_d   = cnt_a_q;
    wr_b_d    = wr_b_q;
    rd_b_d    = rd_b_q;
    cnt_b_d   = cnt_b_q;
    skew_d    = skew_q;
    we_a_d    = 1'b0;
    addr_a_d  = '0;
    data_a_d  = '0;
    we_b_d    = 1'b0;
    addr_b_d  = '0;
    data_b_d  = '0;
    timeout_d = 1'b0;
    ovf_d     = 1'b0;
    if (flush_i || tmo) begin
      wr_a_d  = '0;
      rd_a_d  = '0;
      cnt_a_d = '0;
      wr_b_d  = '0;
      rd_b_d  = '0;
      cnt_b_d = '0;
      skew_d  = '0;
      if (!flush_i) begin
        timeout_d = 1'b1;
        ovf_d     = ovf_hit;
        we_a_d    = ne_a;
        we_b_d    = ne_b;
        if (ne_a) {addr_a_d, data_a_d} = head_a;
        if (ne_b) {addr_b_d, data_b_d} = head_b;
      end
    end else begin
      ovf_d = ovf_hit;
      if (pair) begin
        we_a_d               = 1'b1;
        we_b_d               = 1'b1;
        {addr_a_d, data_a_d} = head_a;
        {addr_b_d, data_b_d} = head_b;
        rd_a_d               = rd_a_q + PW'(1);
        rd_b_d               = rd_b_q + PW'(1);
      end
      if (push_a) wr_a_d = wr_a_q + PW'(1);
      if (push_b) wr_b_d = wr_b_q + PW'(1);
      cnt_a_d = cnt_a_q + CW'(push_a) - CW'(pair);
      cnt_b_d = cnt_b_q + CW'(push_b) - CW'(pair);
      if (!orphan) skew_d = '0;
      else if (skew_q != SW'(TIMEOUT)) skew_d = skew_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_a_q    <= '0;
      rd_a_q    <= '0;
      cnt_a_q   <= '0;
      wr_b_q    <= '0;
      rd_b_q    <= '0;
      cnt_b_q   <= '0;
      skew_q    <= '0;
      we_a_q    <= 1'b0;
      addr_a_q  <= '0;
      data_a_q  <= '0;
      we_b_q    <= 1'b0;
      addr_b_q  <= '0;
      data_b_q  <= '0;
      timeout_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_a_q    <= wr_a_d;
      rd_a_q    <= rd_a_d;
      cnt_a_q   <= cnt_a_d;
      wr_b_q    <= wr_b_d;
      rd_b_q    <= rd_b_d;
      cnt_b_q   <= cnt_b_d;
      skew_q    <= skew_d;
      we_a_q    <= we_a_d;
      addr_a_q  <= addr_a_d;
      data_a_q  <= data_a_d;
      we_b_q    <= we_b_d;
      addr_b_q  <= addr_b_d;
      data_b_q  <= data_b_d;
      timeout_q <= timeout_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read while the count covers them.
  always_ff @(posedge clk_i) begin
    if (push_a) mem_a_q[wr_a_q] <= {addr_a_i, data_a_i};
    if (push_b) mem_b_q[wr_b_q] <= {addr_b_i, data_b_i};
  end

  assign stall_a_o = full_a;
  assign stall_b_o = full_b;
  assign we_a_o    = we_a_q;
  assign addr_a_o  = addr_a_q;
  assign data_a_o  = data_a_q;
  assign we_b_o    = we_b_q;
  assign addr_b_o  = addr_b_q;
  assign data_b_o  = data_b_q;
  assign timeout_o = timeout_q;
  assign ovf_o     = ovf_q;

endmodule
